// File: rtl/bfs_graph_mem_axi_slave.sv
// AXI4 read-only INCR-burst responder over a word-addressed graph RAM with a preload write port.
// Optional out-of-range SLVERR reporting is enabled by defining GRAPH_MEM_BOUNDS_CHECK_EN.
module bfs_graph_mem_axi_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MEM_DEPTH      = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic                          s_axi_rlast,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  input  logic                          ld_en,
  input  logic [$clog2(MEM_DEPTH)-1:0]  ld_addr,
  input  logic [AXI_DATA_WIDTH-1:0]     ld_data
);

  localparam int OFFS   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int IDX_W  = AXI_ADDR_WIDTH - OFFS;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_SEND  = 2'b10
  } state_t;

  state_t                    r_state;
  logic [IDX_W-1:0]          r_idx;
  logic [7:0]                r_cnt;
  logic                      r_arready;
  logic                      r_rvalid;
  logic                      r_rlast;
  logic [1:0]                r_rresp;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic [IDX_W-1:0]          w_ar_idx;
  logic [MEM_AW-1:0]         w_rd_addr;
  logic [AXI_DATA_WIDTH-1:0] w_rd_word;
  logic [1:0]                w_rd_resp;
  logic                      w_unused;

  // Byte offset bits are dropped: unaligned addresses behave as aligned.
  assign w_ar_idx  = s_axi_araddr[AXI_ADDR_WIDTH-1:OFFS];
  assign w_rd_addr = r_idx[MEM_AW-1:0];

`ifdef GRAPH_MEM_BOUNDS_CHECK_EN
  logic w_oob;
  assign w_oob    = (r_idx >= IDX_W'(MEM_DEPTH));
  assign w_unused = |s_axi_araddr[OFFS-1:0];

  // Beat data/response selection with out-of-range words answered as zero + SLVERR
  always_comb begin
    w_rd_word = {AXI_DATA_WIDTH{1'b0}};
    w_rd_resp = 2'b00;
    if (w_oob) begin
      w_rd_word = {AXI_DATA_WIDTH{1'b0}};
      w_rd_resp = 2'b10;
    end else begin
      w_rd_word = r_mem[w_rd_addr];
      w_rd_resp = 2'b00;
    end
  end
`else
  // Without bounds checking the index simply wraps modulo the RAM depth.
  assign w_rd_word = r_mem[w_rd_addr];
  assign w_rd_resp = 2'b00;
  assign w_unused  = ^{s_axi_araddr[OFFS-1:0], r_idx[IDX_W-1:MEM_AW]};
`endif

  // Preload port; RAM is deliberately outside reset so contents survive rst
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // Read FSM: one RAM fetch per beat, all AXI outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= {IDX_W{1'b0}};
      r_cnt     <= 8'd0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= {AXI_DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_axi_arvalid && r_arready) begin
            r_idx     <= w_ar_idx;
            r_cnt     <= s_axi_arlen;
            r_arready <= 1'b0;
            r_state   <= S_FETCH;
          end else begin
            r_arready <= 1'b1;
          end
        end
        S_FETCH: begin
          // Nonblocking RAM access gives read-first behaviour against ld_en.
          r_rdata  <= w_rd_word;
          r_rresp  <= w_rd_resp;
          r_rlast  <= (r_cnt == 8'd0);
          r_rvalid <= 1'b1;
          r_state  <= S_SEND;
        end
        S_SEND: begin
          if (s_axi_rready) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_arready <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_cnt   <= r_cnt - 8'd1;
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rdata   = r_rdata;

endmodule

// File: doc/bfs_graph_mem_axi_slave.md
# bfs_graph_mem_axi_slave

AXI4 read-only responder that serves graph data (CSR row offsets, adjacency lists) from an on-chip word-addressed RAM. It is the target for the BFS system's AXI4 read master port (AR/R channels) in simulation and on-chip deployments. It accepts INCR bursts, returns data with correct `rlast`/`rresp` under `rready` back-pressure, and exposes a simple write port for graph preload.

## Interface

Parameters:
- `AXI_ADDR_WIDTH`, 32: width of `s_axi_araddr`.
- `AXI_DATA_WIDTH`, 64: width of `s_axi_rdata` and of one RAM word. Must be a power of two, ≥ 32.
- `MEM_DEPTH`, 1024: RAM depth in words. Must be a power of two.

Ports:
- `clk`  in  1: sole clock; all logic is on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `s_axi_araddr`  in  AXI_ADDR_WIDTH: byte address of the first beat.
- `s_axi_arlen`  in  8: number of beats in the burst, minus 1.
- `s_axi_arvalid`  in  1: read address valid.
- `s_axi_arready`  out  1: read address ready.
- `s_axi_rdata`  out  AXI_DATA_WIDTH: read data.
- `s_axi_rlast`  out  1: marks the final beat of the burst.
- `s_axi_rresp`  out  2: 2'b00 OKAY, 2'b10 SLVERR.
- `s_axi_rvalid`  out  1: read data valid.
- `s_axi_rready`  in  1: master ready to accept data.
- `ld_en`  in  1: preload write strobe.
- `ld_addr`  in  $clog2(MEM_DEPTH): preload word index.
- `ld_data`  in  AXI_DATA_WIDTH: preload data.

## Operation

- **Word index:** `araddr >> $clog2(AXI_DATA_WIDTH/8)`. Low byte-offset bits are ignored; an unaligned address is treated as aligned.
- **Burst type:** INCR only. The word index increments by 1 per beat and carries no wrap at 4 KB boundaries.
- **State machine:** IDLE → FETCH → SEND.
  - **IDLE:** `arready`=1. On `arvalid && arready`, latch the word index and `arlen` into a beat counter, then go to FETCH.
  - **FETCH:** issue a synchronous RAM read of the current index; `arready`=0 and `rvalid`=0. Next state is SEND.
  - **SEND:** `rvalid`=1. `rdata`, `rresp` and `rlast` are held stable until `rready`.
    - On `rvalid && rready` with `rlast`=1: go to IDLE.
    - Otherwise: increment the index, decrement the counter, and go to FETCH.
- **rlast:** asserted exactly when the beat counter is 0.
- **Preload:** `ld_en` writes `ld_data` to RAM[`ld_addr`] in the same cycle, in any state. On a same-cycle collision with a FETCH read of the same word, the read returns the old data (read-first).
- **RAM contents:** not affected by `rst`.

## Timing

- **Reset values:** `arready`=0, `rvalid`=0, `rlast`=0, `rresp`=2'b00, `rdata`=0, state=IDLE.
  - `arready` rises in the first cycle after `rst` deasserts.
  - `rst` asserted mid-burst aborts the burst at the next edge: `rvalid` drops and the remaining beats are discarded.
- **Latency:** AR handshake at cycle T → FETCH at T+1 → `rvalid`=1 at T+2.
- **Throughput:** one beat per 2 cycles with `rready` held high. A burst of N beats with no stall completes its last handshake at T+2N.
- **AR acceptance:** `arready` is 0 from the cycle after the handshake until the cycle after the last R handshake. Only one burst is outstanding at a time.
- **arvalid vs arready:** `arvalid` high while `arready`=0 is held off, never dropped. The request is accepted on the first cycle back in IDLE.
- **No comb paths:** there is no combinational path from `rready` or `arvalid` to any output; all outputs are registered.

## Configuration

Macro: `GRAPH_MEM_BOUNDS_CHECK_EN`.

- **Defined:** each beat whose word index is ≥ MEM_DEPTH (before truncation) returns `rresp`=2'b10 and `rdata`=0. The burst still completes with the correct beat count and `rlast`. In-range beats of the same burst return OKAY.
- **Undefined:** the word index is truncated modulo MEM_DEPTH, and `rresp` is always 2'b00.

## Test plan

- **Single-beat read:** preload RAM[4]=64'h0000_0005_0000_0003. AR with addr=0x20, len=0, `rready`=1 → `rvalid` at T+2 with that data, `rlast`=1, `rresp`=00; `arready` high again at T+3.
- **4-beat burst:** preload RAM[8..11]=1,2,3,4. AR with addr=0x40, len=3 → beats 1,2,3,4 at T+2, T+4, T+6, T+8; `rlast` only on beat 4.
- **Back-pressure:** repeat the 4-beat burst with `rready` low for 5 cycles on beat 2 → `rdata`=2, `rvalid`=1 and `rlast`=0 held stable; the burst ends 5 cycles later than the unstalled case.
- **Bounds check:** with MEM_DEPTH=1024, AR with addr=0x1FF8 (word 1023), len=1 →
  - macro defined: beat 1 is RAM[1023] with OKAY; beat 2 is 0 with SLVERR and `rlast`=1.
  - macro undefined: beat 2 is RAM[0] with OKAY.
- **Reset mid-burst:** AR with len=7; assert `rst` during beat 3 → `rvalid`=0 the next cycle; `arready`=1 the cycle after `rst` drops; a new single-beat read returns correct data; RAM contents unchanged.
- **Preload collision:** write RAM[6]=0xAA, then in the FETCH cycle of a read of word 6 write 0xBB → the read returns 0xAA; a subsequent read returns 0xBB.
